// File: rtl/trap_sequencer.sv
// Trap-entry sequencer: captures a committing exception, flushes the pipe, writes
// EPC/CAUSE/TVAL through the shared CSR port, then redirects fetch and switches privilege.
module trap_sequencer #(
  parameter int XLEN   = 64,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              except_i,
  input  logic [XLEN-1:0]   epc_i,
  input  logic [XLEN-1:0]   ecause_i,
  input  logic [XLEN-1:0]   etval_i,
  input  logic [1:0]        priv_i,
  input  logic [XLEN-1:0]   medeleg_i,
  input  logic [XLEN-1:0]   mideleg_i,
  input  logic [XLEN-1:0]   mtvec_i,
  input  logic [XLEN-1:0]   stvec_i,
  input  logic              wb_csr_we_i,
  input  logic [CSR_AW-1:0] wb_csr_addr_i,
  input  logic [XLEN-1:0]   wb_csr_wdata_i,
  output logic              csr_we_o,
  output logic [CSR_AW-1:0] csr_addr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              stall_o,
  output logic              flush_o,
  output logic              redirect_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              priv_we_o,
  output logic [1:0]        priv_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    IDLE, FLUSH, WR_EPC, WR_CAUSE, WR_TVAL, REDIRECT
  } state_t;

  localparam logic [CSR_AW-1:0] MEPC   = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] MCAUSE = CSR_AW'(12'h342);
  localparam logic [CSR_AW-1:0] MTVAL  = CSR_AW'(12'h343);
  localparam logic [CSR_AW-1:0] SEPC   = CSR_AW'(12'h141);
  localparam logic [CSR_AW-1:0] SCAUSE = CSR_AW'(12'h142);
  localparam logic [CSR_AW-1:0] STVAL  = CSR_AW'(12'h143);
  localparam logic [1:0]        PRIV_S = 2'd1;
  localparam logic [1:0]        PRIV_M = 2'd3;

  state_t            state;
  logic [XLEN-1:0]   epc_q, cause_q, tval_q, tvec_q;
  logic              tgt_s_q;

  logic              csr_we_q;
  logic [CSR_AW-1:0] csr_addr_q;
  logic [XLEN-1:0]   csr_wdata_q;
  logic              stall_q, flush_q, redirect_q, priv_we_q;
  logic [XLEN-1:0]   rpc_q;
  logic [1:0]        priv_q;

  logic              is_irq, deleg_bit, to_s, idle;
  logic [XLEN-1:0]   vec_base, vec_off, vec_pc;

  // Delegation only ever lowers the target to S when not already running in M.
  assign is_irq    = ecause_i[XLEN-1];
  assign deleg_bit = is_irq ? mideleg_i[ecause_i[5:0]] : medeleg_i[ecause_i[5:0]];
  assign to_s      = (priv_i != PRIV_M) && deleg_bit;

  // Vectored mode offsets interrupts only; modes 2/3 fall back to direct.
  assign vec_base = {tvec_q[XLEN-1:2], 2'b00};
  assign vec_off  = {{(XLEN-8){1'b0}}, cause_q[5:0], 2'b00};
  assign vec_pc   = ((tvec_q[1:0] == 2'b01) && cause_q[XLEN-1]) ? vec_base + vec_off : vec_base;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      epc_q       <= '0;
      cause_q     <= '0;
      tval_q      <= '0;
      tvec_q      <= '0;
      tgt_s_q     <= 1'b0;
      csr_we_q    <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      stall_q     <= 1'b0;
      flush_q     <= 1'b0;
      redirect_q  <= 1'b0;
      priv_we_q   <= 1'b0;
      rpc_q       <= '0;
      priv_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (except_i) begin
            epc_q   <= epc_i;
            cause_q <= ecause_i;
            tval_q  <= etval_i;
            tgt_s_q <= to_s;
            tvec_q  <= to_s ? stvec_i : mtvec_i;
            flush_q <= 1'b1;
            stall_q <= 1'b1;
            state   <= FLUSH;
          end
        end
        FLUSH: begin
          flush_q     <= 1'b0;
          csr_we_q    <= 1'b1;
          csr_addr_q  <= tgt_s_q ? SEPC : MEPC;
          csr_wdata_q <= epc_q;
          state       <= WR_EPC;
        end
        WR_EPC: begin
          csr_addr_q  <= tgt_s_q ? SCAUSE : MCAUSE;
          csr_wdata_q <= cause_q;
          state       <= WR_CAUSE;
        end
        WR_CAUSE: begin
          csr_addr_q  <= tgt_s_q ? STVAL : MTVAL;
          csr_wdata_q <= tval_q;
          state       <= WR_TVAL;
        end
        WR_TVAL: begin
          csr_we_q    <= 1'b0;
          csr_addr_q  <= '0;
          csr_wdata_q <= '0;
          redirect_q  <= 1'b1;
          priv_we_q   <= 1'b1;
          priv_q      <= tgt_s_q ? PRIV_S : PRIV_M;
          rpc_q       <= vec_pc;
          state       <= REDIRECT;
        end
        REDIRECT: begin
          redirect_q <= 1'b0;
          priv_we_q  <= 1'b0;
          priv_q     <= '0;
          rpc_q      <= '0;
          stall_q    <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In IDLE the CSR port belongs to WB; reset still forces it quiet.
  assign idle        = (state == IDLE);
  assign csr_we_o    = idle ? (rst & wb_csr_we_i & ~except_i) : csr_we_q;
  assign csr_addr_o  = idle ? (rst ? wb_csr_addr_i  : '0) : csr_addr_q;
  assign csr_wdata_o = idle ? (rst ? wb_csr_wdata_i : '0) : csr_wdata_q;

  assign stall_o       = stall_q;
  assign busy_o        = stall_q;
  assign flush_o       = flush_q;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = rpc_q;
  assign priv_we_o     = priv_we_q;
  assign priv_o        = priv_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboarded bench for trap_sequencer: expected CSR writes and redirects are queued
// per scenario and consumed by a negedge monitor.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        except_i;
  logic [63:0] epc_i, ecause_i, etval_i;
  logic [1:0]  priv_i;
  logic [63:0] medeleg_i, mideleg_i, mtvec_i, stvec_i;
  logic        wb_csr_we_i;
  logic [11:0] wb_csr_addr_i;
  logic [63:0] wb_csr_wdata_i;
  logic        csr_we_o;
  logic [11:0] csr_addr_o;
  logic [63:0] csr_wdata_o;
  logic        stall_o, flush_o, redirect_o, priv_we_o, busy_o;
  logic [63:0] redirect_pc_o;
  logic [1:0]  priv_o;

  typedef struct packed { logic [11:0] addr; logic [63:0] data; } wr_t;
  typedef struct packed { logic [63:0] pc; logic [1:0] priv; } rd_t;

  wr_t wq[$];
  rd_t rq[$];
  wr_t w_exp;
  rd_t r_exp;
  int  total = 0;
  int  bad   = 0;

  trap_sequencer #(.XLEN(64), .CSR_AW(12)) dut (
    .clk(clk), .rst(rst), .except_i(except_i), .epc_i(epc_i), .ecause_i(ecause_i),
    .etval_i(etval_i), .priv_i(priv_i), .medeleg_i(medeleg_i), .mideleg_i(mideleg_i),
    .mtvec_i(mtvec_i), .stvec_i(stvec_i), .wb_csr_we_i(wb_csr_we_i),
    .wb_csr_addr_i(wb_csr_addr_i), .wb_csr_wdata_i(wb_csr_wdata_i),
    .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
    .stall_o(stall_o), .flush_o(flush_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .priv_we_o(priv_we_o), .priv_o(priv_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_exc(input logic [63:0] epc, input logic [63:0] cause,
                           input logic [63:0] tval, input logic [1:0] priv);
    epc_i    = epc;
    ecause_i = cause;
    etval_i  = tval;
    priv_i   = priv;
    except_i = 1'b1;
  endtask

  // Full sequence: raise except for one edge, then let the six-cycle sequence drain.
  task automatic run_trap(input logic [63:0] epc, input logic [63:0] cause,
                          input logic [63:0] tval, input logic [1:0] priv);
    step();
    drive_exc(epc, cause, tval, priv);
    step();
    except_i = 1'b0;
    repeat (6) step();
  endtask

  task automatic push_trap(input logic s, input logic [63:0] epc, input logic [63:0] cause,
                           input logic [63:0] tval, input logic [63:0] pc);
    wq.push_back(wr_t'{s ? 12'h141 : 12'h341, epc});
    wq.push_back(wr_t'{s ? 12'h142 : 12'h342, cause});
    wq.push_back(wr_t'{s ? 12'h143 : 12'h343, tval});
    rq.push_back(rd_t'{pc, s ? 2'd1 : 2'd3});
  endtask

  task automatic test_reset();
    rst = 1'b0; except_i = 1'b1; wb_csr_we_i = 1'b1; wb_csr_addr_i = 12'h300;
    wb_csr_wdata_i = 64'h5; epc_i = '0; ecause_i = '0; etval_i = '0; priv_i = 2'd3;
    medeleg_i = '0; mideleg_i = '0; mtvec_i = '0; stvec_i = '0;
    #3;
    total++;
    if ({csr_we_o, csr_addr_o, csr_wdata_o, stall_o, flush_o, redirect_o, redirect_pc_o,
         priv_we_o, priv_o, busy_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got we=%b addr=%h data=%h stall=%b flush=%b busy=%b, required all 0",
               csr_we_o, csr_addr_o, csr_wdata_o, stall_o, flush_o, busy_o);
    end
    repeat (2) @(posedge clk);
    #1;
    except_i = 1'b0; wb_csr_we_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({busy_o, flush_o, redirect_o} !== 3'b000) begin
      bad++;
      $display("FAIL reset_release: got busy=%b flush=%b redirect=%b, required 000",
               busy_o, flush_o, redirect_o);
    end
  endtask

  task automatic test_m_trap();
    mtvec_i = 64'h8000_1000; stvec_i = 64'h8000_2000; medeleg_i = '1; mideleg_i = '1;
    push_trap(1'b0, 64'h8000_0010, 64'd2, 64'h13, 64'h8000_1000);
    step();
    drive_exc(64'h8000_0010, 64'd2, 64'h13, 2'd3);
    step();
    except_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++;
        if ({flush_o, stall_o, busy_o, csr_we_o} !== 4'b1110) begin
          bad++;
          $display("FAIL m_flush_cycle: got flush,stall,busy,we=%b, required 1110",
                   {flush_o, stall_o, busy_o, csr_we_o});
        end
      end
      if (k == 5) begin
        total++;
        if (redirect_o !== 1'b1) begin
          bad++;
          $display("FAIL m_redirect_cycle: got redirect=%b, required 1", redirect_o);
        end
      end
      if (k == 6) begin
        total++;
        if ({busy_o, stall_o, redirect_o, priv_we_o, redirect_pc_o, priv_o} !== '0) begin
          bad++;
          $display("FAIL m_idle_after: got busy=%b redirect=%b pc=%h priv=%0d, required 0",
                   busy_o, redirect_o, redirect_pc_o, priv_o);
        end
      end
      step();
    end
    total++;
    if (wq.size() != 0 || rq.size() != 0) begin
      bad++;
      $display("FAIL m_drain: pending writes=%0d redirects=%0d, required 0", wq.size(), rq.size());
    end
  endtask

  task automatic test_deleg();
    mtvec_i = 64'h8000_1000; stvec_i = 64'h8000_2000; medeleg_i = 64'h100; mideleg_i = '0;
    push_trap(1'b1, 64'h8000_0100, 64'd8, 64'h0, 64'h8000_2000);
    run_trap(64'h8000_0100, 64'd8, 64'h0, 2'd0);
    medeleg_i = 64'h0;
    push_trap(1'b0, 64'h8000_0200, 64'd8, 64'h7, 64'h8000_1000);
    run_trap(64'h8000_0200, 64'd8, 64'h7, 2'd1);
    medeleg_i = 64'h100;
    push_trap(1'b0, 64'h8000_0300, 64'd8, 64'h9, 64'h8000_1000);
    run_trap(64'h8000_0300, 64'd8, 64'h9, 2'd3);
    total++;
    if (wq.size() != 0 || rq.size() != 0) begin
      bad++;
      $display("FAIL deleg_drain: pending writes=%0d redirects=%0d, required 0", wq.size(), rq.size());
    end
  endtask

  task automatic test_irq_vec();
    mtvec_i = 64'h8000_1001; stvec_i = 64'h8000_3001; medeleg_i = '0; mideleg_i = '1;
    push_trap(1'b0, 64'h8000_0400, 64'h8000_0000_0000_0007, 64'h0, 64'h8000_101C);
    run_trap(64'h8000_0400, 64'h8000_0000_0000_0007, 64'h0, 2'd3);
    mideleg_i = 64'h20;
    push_trap(1'b1, 64'h8000_0500, 64'h8000_0000_0000_0005, 64'h0, 64'h8000_3014);
    run_trap(64'h8000_0500, 64'h8000_0000_0000_0005, 64'h0, 2'd0);
    push_trap(1'b0, 64'h8000_0600, 64'd2, 64'h33, 64'h8000_1000);
    run_trap(64'h8000_0600, 64'd2, 64'h33, 2'd3);
    mtvec_i = 64'h8000_1002;
    push_trap(1'b0, 64'h8000_0700, 64'h8000_0000_0000_0007, 64'h0, 64'h8000_1000);
    run_trap(64'h8000_0700, 64'h8000_0000_0000_0007, 64'h0, 2'd3);
    total++;
    if (wq.size() != 0 || rq.size() != 0) begin
      bad++;
      $display("FAIL irq_drain: pending writes=%0d redirects=%0d, required 0", wq.size(), rq.size());
    end
  endtask

  task automatic test_csr_passthru();
    mtvec_i = 64'h8000_1000; medeleg_i = '0; mideleg_i = '0;
    step();
    wb_csr_we_i = 1'b1; wb_csr_addr_i = 12'h300; wb_csr_wdata_i = 64'hABC;
    @(negedge clk);
    total++;
    if ({csr_we_o, csr_addr_o, csr_wdata_o} !== {1'b1, 12'h300, 64'hABC}) begin
      bad++;
      $display("FAIL pass_idle: got we=%b addr=%h data=%h, required 1 300 abc",
               csr_we_o, csr_addr_o, csr_wdata_o);
    end
    push_trap(1'b0, 64'h8000_0800, 64'd4, 64'h44, 64'h8000_1000);
    step();
    wb_csr_addr_i = 12'h340; wb_csr_wdata_i = 64'h55;
    drive_exc(64'h8000_0800, 64'd4, 64'h44, 2'd3);
    @(negedge clk);
    total++;
    if (csr_we_o !== 1'b0) begin
      bad++;
      $display("FAIL pass_suppress: got we=%b, required 0", csr_we_o);
    end
    step();
    except_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++;
        if (csr_we_o !== 1'b0) begin
          bad++;
          $display("FAIL pass_flush_block: got we=%b, required 0", csr_we_o);
        end
      end
      if (k == 6) begin
        total++;
        if ({csr_we_o, csr_addr_o, csr_wdata_o} !== {1'b1, 12'h340, 64'h55}) begin
          bad++;
          $display("FAIL pass_resume: got we=%b addr=%h data=%h, required 1 340 55",
                   csr_we_o, csr_addr_o, csr_wdata_o);
        end
      end
      step();
    end
    wb_csr_we_i = 1'b0;
    total++;
    if (wq.size() != 0 || rq.size() != 0) begin
      bad++;
      $display("FAIL pass_drain: pending writes=%0d redirects=%0d, required 0", wq.size(), rq.size());
    end
  endtask

  task automatic test_back_to_back();
    mtvec_i = 64'h8000_1000; stvec_i = 64'h8000_2000; medeleg_i = 64'h100; mideleg_i = '0;
    push_trap(1'b0, 64'h8000_0900, 64'd3, 64'h99, 64'h8000_1000);
    push_trap(1'b1, 64'h8000_0B00, 64'd8, 64'hBB, 64'h8000_2000);
    step();
    drive_exc(64'h8000_0900, 64'd3, 64'h99, 2'd3);
    step();
    except_i = 1'b0;
    step();
    step();
    drive_exc(64'h8000_0A00, 64'd8, 64'hAA, 2'd0);
    step();
    except_i = 1'b0;
    step();
    step();
    drive_exc(64'h8000_0B00, 64'd8, 64'hBB, 2'd0);
    @(negedge clk);
    total++;
    if ({busy_o, redirect_o} !== 2'b00) begin
      bad++;
      $display("FAIL b2b_idle_gap: got busy=%b redirect=%b, required 00", busy_o, redirect_o);
    end
    step();
    except_i = 1'b0;
    @(negedge clk);
    total++;
    if ({flush_o, busy_o} !== 2'b11) begin
      bad++;
      $display("FAIL b2b_flush: got flush=%b busy=%b, required 11", flush_o, busy_o);
    end
    repeat (6) step();
    total++;
    if (wq.size() != 0 || rq.size() != 0) begin
      bad++;
      $display("FAIL b2b_drain: pending writes=%0d redirects=%0d, required 0", wq.size(), rq.size());
    end
  endtask

  task automatic test_reset_mid();
    mtvec_i = 64'h8000_1000; medeleg_i = '0; mideleg_i = '0;
    wq.push_back(wr_t'{12'h341, 64'h8000_0C00});
    wq.push_back(wr_t'{12'h342, 64'd1});
    step();
    drive_exc(64'h8000_0C00, 64'd1, 64'hCC, 2'd3);
    step();
    except_i = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    total++;
    if ({csr_we_o, csr_addr_o, csr_wdata_o, stall_o, flush_o, redirect_o, redirect_pc_o,
         priv_we_o, priv_o, busy_o} !== '0) begin
      bad++;
      $display("FAIL abort_outputs: got we=%b addr=%h stall=%b redirect=%b busy=%b, required all 0",
               csr_we_o, csr_addr_o, stall_o, redirect_o, busy_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({busy_o, flush_o, redirect_o} !== 3'b000) begin
      bad++;
      $display("FAIL abort_idle: got busy=%b flush=%b redirect=%b, required 000",
               busy_o, flush_o, redirect_o);
    end
    repeat (8) step();
    total++;
    if (wq.size() != 0 || rq.size() != 0) begin
      bad++;
      $display("FAIL abort_drain: pending writes=%0d redirects=%0d, required 0", wq.size(), rq.size());
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst === 1'b1) begin
          if (csr_we_o === 1'b1 && busy_o === 1'b1) begin
            total++;
            if (wq.size() == 0) begin
              bad++;
              $display("FAIL csr_write: got addr=%h data=%h, required no write", csr_addr_o, csr_wdata_o);
            end else begin
              w_exp = wq.pop_front();
              if ({csr_addr_o, csr_wdata_o} !== {w_exp.addr, w_exp.data}) begin
                bad++;
                $display("FAIL csr_write: got addr=%h data=%h, required addr=%h data=%h",
                         csr_addr_o, csr_wdata_o, w_exp.addr, w_exp.data);
              end
            end
          end
          if (redirect_o === 1'b1) begin
            total++;
            if (rq.size() == 0) begin
              bad++;
              $display("FAIL redirect: got pc=%h, required no redirect", redirect_pc_o);
            end else begin
              r_exp = rq.pop_front();
              if ({redirect_pc_o, priv_o, priv_we_o} !== {r_exp.pc, r_exp.priv, 1'b1}) begin
                bad++;
                $display("FAIL redirect: got pc=%h priv=%0d priv_we=%b, required pc=%h priv=%0d priv_we=1",
                         redirect_pc_o, priv_o, priv_we_o, r_exp.pc, r_exp.priv);
              end
            end
          end
        end
      end
    join_none
    test_reset();
    test_m_trap();
    test_deleg();
    test_irq_vec();
    test_csr_passthru();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
